// File: rtl/snake_engine.sv
// -----------------------------------------------------------------------------
// snake_engine -- snake game state machine with segment arrays, food placement
// and scoring.
//
// Optional feature: define SNAKE_WRAP_EN to make the head wrap around the board
// edges instead of ending the game.
//
// Ports
//   clk          single clock
//   reset        asynchronous, active-low reset
//   step         one-cycle pulse: advance the game one move (ignored unless IDLE)
//   restart      one-cycle pulse: start a new game (keeps high_score)
//   dir_valid    qualifies dir
//   dir          00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
//   x_values     segment i x-coordinate at [32*i +: 32]; segment 0 is the head
//   y_values     segment i y-coordinate, same packing
//   food_x/y     food tile coordinates
//   score        food eaten in this game
//   high_score   best score since reset
//   game_done    high while the game is over
//   busy         high while a step is being processed
//
// Unused segment slots read 32'hFFFFFFFF.
// -----------------------------------------------------------------------------
module snake_engine #(
    parameter int GRID_W    = 10,
    parameter int GRID_H    = 10,
    parameter int MAX_LEN   = 100,
    parameter int START_LEN = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   step,
    input  logic                   restart,
    input  logic                   dir_valid,
    input  logic [1:0]             dir,
    output logic [32*MAX_LEN-1:0]  x_values,
    output logic [32*MAX_LEN-1:0]  y_values,
    output logic [31:0]            food_x,
    output logic [31:0]            food_y,
    output logic [31:0]            score,
    output logic [31:0]            high_score,
    output logic                   game_done,
    output logic                   busy
);

    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;
    localparam logic [31:0] W32   = 32'(GRID_W);
    localparam logic [31:0] H32   = 32'(GRID_H);
    localparam int          IW    = $clog2(MAX_LEN);      // array index width
    localparam int          CW    = $clog2(MAX_LEN + 1);  // length/count width
    localparam logic [CW-1:0] CELLS = CW'(GRID_W * GRID_H);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [2:0] {IDLE, CHECK, MOVE, FOOD, DONE} state_t;

    state_t         state, state_nx;
    logic [31:0]    seg_x [MAX_LEN];
    logic [31:0]    seg_y [MAX_LEN];
    logic [CW-1:0]  len, idx, scan_end;
    logic [31:0]    nh_x, nh_y;       // head position computed at step accept
    logic [31:0]    cand_x, cand_y;   // current food candidate
    logic [31:0]    step_x, step_y;   // head position if a step were taken now
    logic [1:0]     cur_dir, pend_dir;
    logic           eat, off_board, scan_hit, cand_off;
    logic [15:0]    lfsr;

    function automatic logic [31:0] init_x(input int i);
        return (i < START_LEN) ? 32'(GRID_W / 2 - i) : EMPTY;
    endfunction

    function automatic logic [31:0] init_y(input int i);
        return (i < START_LEN) ? 32'(GRID_H / 2) : EMPTY;
    endfunction

    // Candidate next head from the current head and the pending direction.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        step_x = seg_x[0];
        step_y = seg_y[0];
        case (pend_dir)
            DIR_UP:    step_y = seg_y[0] - 32'd1;
            DIR_RIGHT: step_x = seg_x[0] + 32'd1;
            DIR_DOWN:  step_y = seg_y[0] + 32'd1;
            DIR_LEFT:  step_x = seg_x[0] - 32'd1;
            default:   ;
        endcase
`ifdef SNAKE_WRAP_EN
        // Moving off an edge is exactly one tile out: -1 (all ones) or GRID.
        if (step_x == EMPTY)    step_x = W32 - 32'd1;
        else if (step_x == W32) step_x = '0;
        if (step_y == EMPTY)    step_y = H32 - 32'd1;
        else if (step_y == H32) step_y = '0;
        off_board = 1'b0;
`else
        // Unsigned compare also catches -1 (wrapped to all ones).
        off_board = (step_x >= W32) || (step_y >= H32);
`endif
    end

    // Shared one-segment-per-cycle scanner for CHECK (against the next head)
    // and FOOD (against the candidate). When not eating, the tail vacates its
    // tile during the move, so it is excluded from the collision scan.
    always_comb begin
        scan_end = len;
        if (state == CHECK && !eat)
            scan_end = len - CW'(1);
        cand_off = (cand_x >= W32) || (cand_y >= H32);
        scan_hit = 1'b0;
        if (idx < scan_end) begin
            if (state == FOOD)
                scan_hit = (seg_x[idx[IW-1:0]] == cand_x) && (seg_y[idx[IW-1:0]] == cand_y);
            else
                scan_hit = (seg_x[idx[IW-1:0]] == nh_x) && (seg_y[idx[IW-1:0]] == nh_y);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (step) state_nx = off_board ? DONE : CHECK;
            CHECK: if (scan_hit) state_nx = DONE;
                   else if (idx >= scan_end) state_nx = MOVE;
            MOVE:  if (!eat) state_nx = IDLE;
                   else if (len + CW'(1) == CELLS) state_nx = DONE;
                   else state_nx = FOOD;
            FOOD:  if (!cand_off && !scan_hit && idx >= len) state_nx = IDLE;
            DONE:  state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (restart)
            state_nx = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            high_score <= '0;
        else if (!restart && state == MOVE && eat && (score + 32'd1) > high_score)
            high_score <= score + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the segment arrays are architectural outputs with defined
            // reset contents, so they are reset as registers rather than
            // treated as a RAM.
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= init_y(i);
            end
            len      <= CW'(START_LEN);
            score    <= '0;
            food_x   <= W32 - 32'd2;
            food_y   <= H32 / 32'd2;
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            nh_x     <= '0;
            nh_y     <= '0;
            cand_x   <= '0;
            cand_y   <= '0;
            idx      <= '0;
            eat      <= 1'b0;
        end else if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= init_y(i);
            end
            len      <= CW'(START_LEN);
            score    <= '0;
            food_x   <= W32 - 32'd2;
            food_y   <= H32 / 32'd2;
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            idx      <= '0;
            eat      <= 1'b0;
        end else begin
            // A direct reversal relative to the last applied direction is dropped.
            if (dir_valid && dir != (cur_dir ^ 2'b10))
                pend_dir <= dir;

            case (state)
                IDLE: if (step) begin
                    cur_dir <= pend_dir;
                    nh_x    <= step_x;
                    nh_y    <= step_y;
                    eat     <= (step_x == food_x) && (step_y == food_y);
                    idx     <= '0;
                end
                CHECK: idx <= idx + CW'(1);
                MOVE: begin
                    seg_x[0] <= nh_x;
                    seg_y[0] <= nh_y;
                    for (int i = 1; i < MAX_LEN; i++) begin
                        // Without an eat, the old tail slot becomes empty.
                        if (!eat && CW'(i) == len) begin
                            seg_x[i] <= EMPTY;
                            seg_y[i] <= EMPTY;
                        end else begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                    end
                    if (eat) begin
                        len   <= len + CW'(1);
                        score <= score + 32'd1;
                    end
                    idx    <= '0;
                    cand_x <= {28'd0, lfsr[3:0]};
                    cand_y <= {28'd0, lfsr[7:4]};
                end
                FOOD: begin
                    if (cand_off || scan_hit) begin
                        cand_x <= {28'd0, lfsr[3:0]};
                        cand_y <= {28'd0, lfsr[7:4]};
                        idx    <= '0;
                    end else if (idx >= len) begin
                        food_x <= cand_x;
                        food_y <= cand_y;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign x_values[32*g +: 32] = seg_x[g];
        assign y_values[32*g +: 32] = seg_y[g];
    end

    assign game_done = (state == DONE);
    assign busy      = (state == CHECK) || (state == MOVE) || (state == FOOD);

endmodule
